// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: operands are captured on an accepted start, added LSB
// first through a single 1-bit datapath, and the result is published on DONE.
module serial_add_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sh_a;
    logic [N-1:0]  sh_b;
    logic [N-1:0]  res;
    logic          carry;
    logic [CW-1:0] cnt;

    // Shared 1-bit datapath: two half adders with their carries ORed.
    logic bit_a, bit_b, h1, g1, s_bit, g2, c_next;
    assign bit_a  = sh_a[0];
    assign bit_b  = sh_b[0];
    assign h1     = bit_a ^ bit_b;
    assign g1     = bit_a & bit_b;
    assign s_bit  = h1 ^ carry;
    assign g2     = h1 & carry;
    assign c_next = g1 | g2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= c_next;
                    res   <= {s_bit, res[N-1:1]};
                    cnt   <= cnt + CW'(1);
                    // Final bit: publish the completed result on the way into DONE.
                    if (cnt == LAST) begin
                        sum   <= {s_bit, res[N-1:1]};
                        cout  <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits; legal range is N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: operand A, captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, N bits: operand B, captured on the accepted start edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-009 The block SHALL have port sum, output, N bits: registered result of the last completed addition.
REQ-010 The block SHALL have port cout, output, 1 bit: registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL add a and b bit-serially, LSB first, through one shared 1-bit datapath: two half-adder stages plus OR for carry, one bit per RUN cycle.
REQ-012 The block SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with no other states.
REQ-013 In IDLE with start=1 at edge t, the block SHALL load a and b into shift registers, clear the carry flop and bit counter, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE and SHALL NOT alter sum or cout.
REQ-015 In RUN, each edge SHALL compute the bit: s_i = a_i ^ b_i ^ c, c' = (a_i&b_i) | (c&(a_i^b_i)); s_i is shifted into the result register from the MSB end; the counter increments.
REQ-016 RUN SHALL last exactly N cycles (edges t+1..t+N); on edge t+N the block SHALL load sum with the N-bit result and cout with the final carry, then enter DONE.
REQ-017 DONE SHALL last exactly one cycle; on edge t+N+1 the block SHALL return to IDLE unconditionally.
REQ-018 Total latency SHALL be: done high in the cycle following edge t+N, i.e. N+1 cycles after the start edge t.
REQ-019 start SHALL be ignored in RUN and DONE: no operand reload, no restart, and no change in timing.
REQ-020 Back-to-back operation: start held high SHALL be accepted at the first IDLE edge after DONE, giving a period of N+2 cycles per addition.
REQ-021 sum and cout SHALL change only on the RUN->DONE edge, and SHALL hold stable through IDLE and the next RUN.
REQ-022 Arithmetic SHALL be modulo 2^N on sum; the overflow bit SHALL appear only on cout; there is no carry-in.
REQ-023 Changes on a and b after the accepted start edge SHALL NOT affect the result.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL enter IDLE and clear to 0: busy, done, sum, cout, the carry flop, the counter, and the shift registers.
REQ-025 rst SHALL take priority over start and over any state, including mid-RUN; an interrupted addition SHALL produce no done and SHALL leave sum=0 and cout=0.
REQ-026 After rst deasserts, the first edge with start=1 in IDLE SHALL be accepted normally.

Verification (N=4)
REQ-027 a=5, b=3, start pulse -> busy high 4 cycles, then done=1 for one cycle with sum=8, cout=0.
REQ-028 a=15, b=1 -> sum=0, cout=1; a=15, b=15 -> sum=14, cout=1; a=0, b=0 -> sum=0, cout=0.
REQ-029 start=1 with a=1, b=1 in RUN of a 5+3 operation -> result remains sum=8; exactly one done pulse; no extra operation.
REQ-030 start held high continuously with operands 2+2 then 7+9 -> done pulses 6 cycles apart; results sum=4/cout=0, then sum=0/cout=1.
REQ-031 rst=1 on the 2nd RUN cycle of 9+9 -> next cycle busy=0, done=0, sum=0, cout=0; 6+1 afterwards gives sum=7, cout=0.
REQ-032 An exhaustive sweep of all 256 a/b pairs SHALL match {cout,sum} = a+b, with each done exactly N+1 cycles after its start edge.
